// File: rtl/conv_job_sequencer.sv
// conv_job_sequencer
//   Host-side controller for the convolution core. Takes (sizeX, sizeY) jobs
//   over a valid/ready port, rejects zero-sized jobs, programs the core config
//   word, pulses start, waits for done under a timeout, then streams the
//   sizeX+sizeY-1 results out of the memZ read port as a valid/ready stream.
//
// Ports
//   clk, rstn                    clock (rising edge), async active-low reset
//   job_valid_i/job_ready_o      job request handshake
//   job_sizeX_i/job_sizeY_i      job sequence lengths
//   config_o, start_o            core configuration word and start pulse
//   core_busy_i, core_done_i     core status
//   memZ_rd_addr_o/_data_i       memZ read port (1-cycle registered read)
//   res_valid_o/res_ready_i      result stream handshake
//   res_data_o, res_last_o       result word and end-of-job marker
//   job_done_o                   pulse after the final result handshake
//   err_o, err_code_o            error pulse; code 01=zero size, 10=timeout
//   busy_o                       high whenever not idle
//   jobs_done_o                  completed-job counter, wraps at 256
module conv_job_sequencer #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    job_valid_i,
  output logic                    job_ready_o,
  input  logic [ADDR_WIDTH-1:0]   job_sizeX_i,
  input  logic [ADDR_WIDTH-1:0]   job_sizeY_i,
  output logic [DATA_WIDTH-1:0]   config_o,
  output logic                    start_o,
  input  logic                    core_busy_i,
  input  logic                    core_done_i,
  output logic [ADDR_WIDTH:0]     memZ_rd_addr_o,
  input  logic [2*DATA_WIDTH-1:0] memZ_rd_data_i,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic [2*DATA_WIDTH-1:0] res_data_o,
  output logic                    res_last_o,
  output logic                    job_done_o,
  output logic                    err_o,
  output logic [1:0]              err_code_o,
  output logic                    busy_o,
  output logic [7:0]              jobs_done_o
);

  localparam int unsigned LW = ADDR_WIDTH + 1;
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  // Expiry compare value chosen so err_o lands exactly TIMEOUT_CYCLES cycles
  // after the start_o cycle (counter reads 0 in the first WAIT cycle).
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 2);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LAUNCH  = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_RD_ADDR = 3'd3;
  localparam logic [2:0] S_RD_CAP  = 3'd4;
  localparam logic [2:0] S_OUT     = 3'd5;
  localparam logic [2:0] S_FIN     = 3'd6;

  logic [2:0]              state_q,    state_d;
  logic [DATA_WIDTH-1:0]   config_q,   config_d;
  logic [LW-1:0]           idx_q,      idx_d;
  logic [LW-1:0]           len_q,      len_d;
  logic [LW-1:0]           addr_q,     addr_d;
  logic [CW-1:0]           cnt_q,      cnt_d;
  logic [2*DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic                    err_q,      err_d;
  logic [1:0]              err_code_q, err_code_d;
  logic [7:0]              jobs_q,     jobs_d;

  logic                    job_hs;
  logic                    is_last;
  logic [DATA_WIDTH-1:0]   cfg_new;
  logic [LW-1:0]           len_new;

  // Ready is held low during the error pulse cycle and while in reset.
  assign job_ready_o = rstn && (state_q == S_IDLE) && !core_busy_i && !err_q;
  assign job_hs      = job_valid_i && job_ready_o;
  assign is_last     = (idx_q == len_q - LW'(1));
  assign len_new     = {1'b0, config_q[ADDR_WIDTH-1:0]}
                     + {1'b0, config_q[2*ADDR_WIDTH-1:ADDR_WIDTH]} - LW'(1);

  always_comb begin
    cfg_new = '0;
    cfg_new[ADDR_WIDTH-1:0]            = job_sizeX_i;
    cfg_new[2*ADDR_WIDTH-1:ADDR_WIDTH] = job_sizeY_i;
  end

  always_comb begin
    state_d    = state_q;
    config_d   = config_q;
    idx_d      = idx_q;
    len_d      = len_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    res_data_d = res_data_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    jobs_d     = jobs_q;
    case (state_q)
      S_IDLE: begin
        if (job_hs) begin
          err_code_d = '0;
          if (job_sizeX_i == '0 || job_sizeY_i == '0) begin
            err_d      = 1'b1;
            err_code_d = 2'b01;
          end else begin
            config_d = cfg_new;
            state_d  = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (core_done_i) begin
          idx_d   = '0;
          addr_d  = '0;
          len_d   = len_new;
          state_d = S_RD_ADDR;
        end else if (cnt_q == TO_LAST) begin
          err_d      = 1'b1;
          err_code_d = 2'b10;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RD_ADDR: state_d = S_RD_CAP;
      S_RD_CAP: begin
        res_data_d = memZ_rd_data_i;
        state_d    = S_OUT;
      end
      S_OUT: begin
        if (res_ready_i) begin
          if (is_last) begin
            state_d = S_FIN;
          end else begin
            idx_d   = idx_q + LW'(1);
            addr_d  = idx_q + LW'(1);
            state_d = S_RD_ADDR;
          end
        end
      end
      S_FIN: begin
        jobs_d  = jobs_q + 8'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      config_q   <= '0;
      idx_q      <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      res_data_q <= '0;
      err_q      <= 1'b0;
      err_code_q <= '0;
      jobs_q     <= '0;
    end else begin
      state_q    <= state_d;
      config_q   <= config_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      res_data_q <= res_data_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      jobs_q     <= jobs_d;
    end
  end

  assign config_o       = config_q;
  assign start_o        = (state_q == S_LAUNCH);
  assign memZ_rd_addr_o = addr_q;
  assign res_valid_o    = (state_q == S_OUT);
  assign res_data_o     = res_data_q;
  assign res_last_o     = (state_q == S_OUT) && is_last;
  assign job_done_o     = (state_q == S_FIN);
  assign err_o          = err_q;
  assign err_code_o     = err_code_q;
  assign busy_o         = (state_q != S_IDLE);
  assign jobs_done_o    = jobs_q;

endmodule
